// File: rtl/serial_encoder_4x2.sv
// Sequential 4-to-2 encoder: accepts a 4-bit request word over valid/ready
// and emits the 2-bit index of every set bit, highest index first, one code
// per output handshake. All outputs are decoded from registered state only.
module serial_encoder_4x2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic in_valid,
    output logic in_ready,
    output logic o0,
    output logic o1,
    output logic out_valid,
    input  logic out_ready,
    output logic out_last,
    output logic zero_err
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] pend;
    logic [3:0] pend_nxt;
    logic       zero_err_nxt;
    logic       alive;
    logic [3:0] word;
    logic [1:0] top_idx;
    logic       one_left;

    assign word = {i3, i2, i1, i0};

    // Index of the highest pending bit and whether it is the only one left.
    always_comb begin
        top_idx = 2'd0;
        if (pend[3]) begin
            top_idx = 2'd3;
        end else if (pend[2]) begin
            top_idx = 2'd2;
        end else if (pend[1]) begin
            top_idx = 2'd1;
        end
        one_left = (pend != '0) && ((pend & (pend - 4'd1)) == '0);
    end

    // Output decode from registered state; 'alive' keeps in_ready low during
    // reset and lets it rise only after the first clock following release.
    always_comb begin
        out_valid = (state == EMIT);
        in_ready  = alive && (state == IDLE);
        {o1, o0}  = out_valid ? top_idx : 2'b00;
        out_last  = out_valid && one_left;
    end

    // Next-state: load on a nonzero request, flag zero words, retire one
    // pending bit per output handshake.
    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        zero_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (word != '0) begin
                        pend_nxt  = word;
                        state_nxt = EMIT;
                    end else begin
                        zero_err_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_nxt = pend & ~(4'b0001 << top_idx);
                    if (one_left) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            zero_err <= 1'b0;
            alive    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            zero_err <= zero_err_nxt;
            alive    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_encoder_4x2.sv
// Testbench for serial_encoder_4x2: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_serial_encoder_4x2;

    logic clk = 1'b0;
    logic rst_n;
    logic i0, i1, i2, i3;
    logic in_valid;
    logic in_ready;
    logic o0, o1;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic zero_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: queue of indices still to be emitted for the current word.
    int q[$];
    bit m_alive;
    bit m_zero;

    serial_encoder_4x2 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i0       (i0),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .o0       (o0),
        .o1       (o1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .zero_err (zero_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        q.delete();
        m_alive = 1'b0;
        m_zero  = 1'b0;
    endfunction

    // Advance the model across one rising edge using the inputs seen at that edge.
    function automatic void model_edge();
        logic [3:0] w;
        bit         fresh_zero;
        w = {i3, i2, i1, i0};
        if (!rst_n) begin
            model_reset();
            return;
        end
        fresh_zero = 1'b0;
        if (q.size() == 0) begin
            if (m_alive && in_valid) begin
                if (w == 4'd0) begin
                    fresh_zero = 1'b1;
                end else begin
                    for (int b = 3; b >= 0; b--) begin
                        if (w[b]) q.push_back(b);
                    end
                end
            end
        end else if (out_ready) begin
            void'(q.pop_front());
        end
        m_zero  = fresh_zero;
        m_alive = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic [1:0] exp_code;
        exp_code = (q.size() != 0) ? 2'(q[0]) : 2'd0;
        chk({tag, ".out_valid"}, out_valid, q.size() != 0);
        chk({tag, ".code"},      {o1, o0},  exp_code);
        chk({tag, ".out_last"},  out_last,  q.size() == 1);
        chk({tag, ".in_ready"},  in_ready,  m_alive && (q.size() == 0));
        chk({tag, ".zero_err"},  zero_err,  m_zero);
    endtask

    task automatic drive(input logic [3:0] w, input logic v, input logic r);
        {i3, i2, i1, i0} = w;
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held with random inputs: every output low.
        rst_n = 1'b0;
        drive(4'($urandom), 1'($urandom), 1'($urandom));
        model_reset();
        #1;
        check_all("rst0");
        chk("rst0.in_ready_low", in_ready, 1'b0);
        for (int n = 0; n < 3; n++) begin
            drive(4'($urandom), 1'($urandom), 1'($urandom));
            step("rst_hold");
        end

        // Release between edges: in_ready rises after the next edge.
        rst_n = 1'b1;
        drive(4'b0000, 1'b0, 1'b1);
        step("release");
        chk("release.in_ready", in_ready, 1'b1);

        // Single bit 0100 -> code 10 with out_last, then idle.
        drive(4'b0100, 1'b1, 1'b1);
        step("single");
        chk("single.code_10", {o1, o0}, 2'b10);
        chk("single.last",    out_last, 1'b1);
        drive(4'b0000, 1'b0, 1'b1);
        step("single_done");
        chk("single_done.in_ready", in_ready, 1'b1);

        // Multi bit 1011 -> 11, 01, 00 with out_last only on 00.
        drive(4'b1011, 1'b1, 1'b1);
        step("multi0");
        chk("multi0.code_11", {o1, o0}, 2'b11);
        drive(4'b0000, 1'b0, 1'b1);
        step("multi1");
        chk("multi1.code_01", {o1, o0}, 2'b01);
        step("multi2");
        chk("multi2.code_00", {o1, o0}, 2'b00);
        chk("multi2.last",    out_last, 1'b1);
        step("multi_done");

        // Backpressure on 1111: code 11 held, then 11, 10, 01, 00.
        drive(4'b1111, 1'b1, 1'b0);
        step("bp_load");
        drive(4'b0000, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step("bp_hold");
        chk("bp_hold.code_11", {o1, o0}, 2'b11);
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) step("bp_drain");
        step("bp_done");

        // Zero word: one-cycle zero_err, no out_valid.
        drive(4'b0000, 1'b1, 1'b1);
        step("zero");
        chk("zero.pulse", zero_err, 1'b1);
        drive(4'b0000, 1'b0, 1'b1);
        step("zero_after");
        chk("zero_after.pulse_gone", zero_err, 1'b0);

        // Request offered during EMIT is ignored: 0011 gives only 01, 00.
        drive(4'b0011, 1'b1, 1'b1);
        step("ign0");
        drive(4'b1000, 1'b1, 1'b1);
        step("ign1");
        chk("ign1.code_00", {o1, o0}, 2'b00);
        drive(4'b0000, 1'b0, 1'b1);
        step("ign_done");
        chk("ign_done.idle", out_valid, 1'b0);

        // Asynchronous reset mid-EMIT drops out_valid without a clock.
        drive(4'b1111, 1'b1, 1'b1);
        step("mid0");
        drive(4'b0000, 1'b0, 1'b1);
        step("mid1");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_rst");
        chk("mid_rst.out_valid_low", out_valid, 1'b0);
        step("mid_rst_hold");
        rst_n = 1'b1;
        step("mid_release");
        step("mid_idle");
        chk("mid_idle.in_ready", in_ready, 1'b1);

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            drive(w, 1'($urandom), ($urandom_range(0, 3) != 0));
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
